multi_dataflow_kernel_adapter_mc: RTL and testbench
===================================================

Name: multi_dataflow_kernel_adapter_mc

Overview:
- Parametrised multi-channel kernel adapter between the HWPE streamers/engine and a multi_dataflow reconfigurable datapath with N_IN sink and N_OUT source streams.
- Gates input handshakes while a job runs, counts accepted beats per stream, and emits per-stream event pulses.
- Signals job completion when every output stream has delivered its programmed beat count.
- Stream data buses bypass this block; only valid/ready pass through or are snooped.

Parameters:
N_IN, 2, number of kernel input streams (>=1)
N_OUT, 2, number of kernel output streams (>=1)
CNT_W, 16, width of every beat counter and programmed count

Ports:
clk_i  in  1  clock
rst_i  in  1  reset: synchronous, active-high
clear_i  in  1  soft clear; same effect as rst_i
start_i  in  1  job start pulse
tot_out_i  in  N_OUT*CNT_W  beats expected per output stream per job (slice j = stream j)
in_ratio_i  in  N_IN*CNT_W  accepted inputs per in_evt_o pulse, per input stream (0 treated as 1)
in_valid_i  in  N_IN  streamer-side valid per input stream
in_ready_o  out  N_IN  streamer-side ready = k_in_ready_i[i] & run
k_in_valid_o  out  N_IN  kernel-side valid = in_valid_i[i] & run
k_in_ready_i  in  N_IN  kernel-side ready
out_valid_i  in  N_OUT  snooped kernel output valid
out_ready_i  in  N_OUT  snooped output ready
in_evt_o  out  N_IN  one-cycle pulse per completed input group
out_evt_o  out  N_OUT  one-cycle pulse per accepted output beat
out_cnt_o  out  N_OUT*CNT_W  current output beat count per stream
done_o  out  1  one-cycle job-complete pulse
idle_o  out  1  high when FSM in IDLE
err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i or clear_i high at a clock edge; rst_i and clear_i are equivalent, no priority issue):
  - FSM=IDLE, all counters 0, latched config 0.
  - in_evt_o, out_evt_o and done_o 0; err_o 0; idle_o 1.
- Reset mid-job aborts the job immediately: no done_o pulse, and in_ready_o/k_in_valid_o drop in the next cycle.
- FSM states: IDLE, RUN, DONE. run = (state==RUN).
- IDLE + start_i:
  - Latch tot_out_i and in_ratio_i (a 0 ratio is latched as 1).
  - Zero all counters and go to RUN.
  - idle_o falls in the cycle after start_i.
- start_i in RUN or DONE is ignored, with no relatch.
- RUN:
  - complete = AND over j of (out_cnt[j]==tot_lat[j]).
  - If complete, next state is DONE.
  - A stream with tot_lat==0 counts as complete from entry; all-zero totals give RUN for exactly 1 cycle.
- DONE: done_o=1 for exactly this one cycle, then unconditionally IDLE.
- Done latency: final output handshake at cycle t -> counter updated at t+1 -> DONE/done_o at t+2 -> IDLE/idle_o=1 at t+3.
- Input path:
  - Pass-through is combinational with zero latency; outside RUN, in_ready_o=0 and k_in_valid_o=0.
  - Accepted input i = in_valid_i[i] & k_in_ready_i[i] & run.
  - Group counter gcnt[i] increments on each accept.
  - On the accept where gcnt[i]==ratio_lat[i]-1, gcnt wraps to 0 and in_evt_o[i]=1 in the next cycle (registered pulse).
  - Back-to-back groups with ratio 1 give in_evt_o high on consecutive cycles.
- Output snoop:
  - Accepted output j = out_valid_i[j] & out_ready_i[j].
  - out_evt_o[j] pulses the cycle after every accepted output, in any state.
  - In RUN with out_cnt[j] < tot_lat[j]: out_cnt[j] increments.
  - At out_cnt[j]==tot_lat[j] the counter holds (saturates).
  - Simultaneous final beats on several streams in one cycle complete the job normally.
- err_o is set (sticky until reset/clear) on:
  - any accepted output while not in RUN;
  - any accepted output on a stream already at tot_lat.
- Arithmetic: all counters are unsigned CNT_W, and no counter wraps except gcnt.
- Totals up to 2^CNT_W-1 are legal.

Test Plan:
- N_IN=N_OUT=2, tot_out={4,4}, ratio={1,2}; 4 inputs on each stream, 4 outputs each -> in_evt_o[0] pulses 4x, in_evt_o[1] 2x, done_o one pulse 2 cycles after last output, idle_o=1 next cycle, err_o=0.
- Streams complete at different times (tot={3,6}), stream 0 finished early -> out_cnt_o holds at 3, done_o only after the 6th beat on stream 1.
- tot_out={0,0}, start_i -> RUN 1 cycle, done_o at cycle start+2, no input accepted.
- Extra output beat after out_cnt==tot, or output while IDLE -> err_o rises next cycle and stays high until clear_i; clear_i -> all outputs return to reset values.
- rst_i asserted mid-RUN with inputs streaming -> in_ready_o=0 next cycle, no done_o; start_i while RUN -> ignored, counts unchanged.
- ratio_i=0 and CNT_W=4 with tot=15 -> ratio treated as 1; counter reaches 15 without wrap, done_o asserted.

Source files
------------

// File: rtl/multi_dataflow_kernel_adapter_mc.sv
// Kernel adapter between HWPE streamers/engine and a multi_dataflow datapath.
// Gates input handshakes while a job runs, counts accepted beats per stream,
// emits per-stream event pulses and signals job completion once every output
// stream has delivered its programmed beat count. Data buses bypass this block.
module multi_dataflow_kernel_adapter_mc #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [N_OUT*CNT_W-1:0] tot_out_i,
    input  logic [N_IN*CNT_W-1:0]  in_ratio_i,
    input  logic [N_IN-1:0]        in_valid_i,
    output logic [N_IN-1:0]        in_ready_o,
    output logic [N_IN-1:0]        k_in_valid_o,
    input  logic [N_IN-1:0]        k_in_ready_i,
    input  logic [N_OUT-1:0]       out_valid_i,
    input  logic [N_OUT-1:0]       out_ready_i,
    output logic [N_IN-1:0]        in_evt_o,
    output logic [N_OUT-1:0]       out_evt_o,
    output logic [N_OUT*CNT_W-1:0] out_cnt_o,
    output logic                   done_o,
    output logic                   idle_o,
    output logic                   err_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic             srst;
    logic             run;
    logic             start_fire;
    logic             complete;

    logic [CNT_W-1:0] tot_lat   [N_OUT];
    logic [CNT_W-1:0] ratio_lat [N_IN];
    logic [CNT_W-1:0] gcnt      [N_IN];
    logic [CNT_W-1:0] out_cnt   [N_OUT];

    logic [N_IN-1:0]  in_acc;
    logic [N_OUT-1:0] out_acc;
    logic [N_OUT-1:0] out_full;
    logic [N_OUT-1:0] out_bad;

    // Soft clear and reset are interchangeable.
    assign srst       = rst_i | clear_i;
    assign run        = (state == ST_RUN);
    assign start_fire = (state == ST_IDLE) && start_i;

    // Handshake gating is purely combinational so the pass-through adds no latency.
    assign in_ready_o   = k_in_ready_i & {N_IN{run}};
    assign k_in_valid_o = in_valid_i & {N_IN{run}};
    assign in_acc       = in_valid_i & k_in_ready_i & {N_IN{run}};

    assign out_acc = out_valid_i & out_ready_i;
    // A beat is illegal outside RUN or on a stream that already reached its total.
    assign out_bad = out_acc & (~{N_OUT{run}} | out_full);

    assign done_o = (state == ST_DONE);
    assign idle_o = (state == ST_IDLE);

    // Per-stream completion flags and the job-complete reduction.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        out_full = '0;
        for (int j = 0; j < N_OUT; j++) begin
            out_full[j] = (out_cnt[j] == tot_lat[j]);
        end
        complete = &out_full;
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_cnt_pack
        assign out_cnt_o[j*CNT_W +: CNT_W] = out_cnt[j];
    end

    // Job FSM and configuration latch.
    always_ff @(posedge clk_i) begin
        if (srst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= ST_IDLE;
            for (int j = 0; j < N_OUT; j++) tot_lat[j] <= '0;
            for (int i = 0; i < N_IN; i++) ratio_lat[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        for (int j = 0; j < N_OUT; j++) begin
                            tot_lat[j] <= tot_out_i[j*CNT_W +: CNT_W];
                        end
                        // A zero ratio would never produce an event; treat it as one.
                        for (int i = 0; i < N_IN; i++) begin
                            ratio_lat[i] <= (in_ratio_i[i*CNT_W +: CNT_W] == '0) ?
                                            ONE : in_ratio_i[i*CNT_W +: CNT_W];
                        end
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (complete) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Input group counters; an event pulses the cycle after a group closes.
    always_ff @(posedge clk_i) begin
        if (srst) begin
            in_evt_o <= '0;
            for (int i = 0; i < N_IN; i++) gcnt[i] <= '0;
        end else begin
            in_evt_o <= '0;
            for (int i = 0; i < N_IN; i++) begin
                if (start_fire) begin
                    gcnt[i] <= '0;
                end else if (in_acc[i]) begin
                    if (gcnt[i] == ratio_lat[i] - ONE) begin
                        gcnt[i]     <= '0;
                        in_evt_o[i] <= 1'b1;
                    end else begin
                        gcnt[i] <= gcnt[i] + ONE;
                    end
                end
            end
        end
    end

    // Output beat counters (saturating), beat events and sticky protocol error.
    always_ff @(posedge clk_i) begin
        if (srst) begin
            out_evt_o <= '0;
            err_o     <= 1'b0;
            for (int j = 0; j < N_OUT; j++) out_cnt[j] <= '0;
        end else begin
            out_evt_o <= out_acc;
            if (|out_bad) err_o <= 1'b1;
            for (int j = 0; j < N_OUT; j++) begin
                if (start_fire) begin
                    out_cnt[j] <= '0;
                end else if (run && out_acc[j] && !out_full[j]) begin
                    out_cnt[j] <= out_cnt[j] + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_dataflow_kernel_adapter_mc.sv
// Self-checking bench: a job-level behavioural model is compared against the
// DUT on every cycle, plus hand-computed directed expectations per scenario.
module tb_multi_dataflow_kernel_adapter_mc;

    localparam int N_IN  = 2;
    localparam int N_OUT = 2;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   clear = 1'b0;
    logic                   start = 1'b0;
    logic [N_OUT*CNT_W-1:0] tot_out = '0;
    logic [N_IN*CNT_W-1:0]  in_ratio = '0;
    logic [N_IN-1:0]        in_valid = '0;
    logic [N_IN-1:0]        in_ready;
    logic [N_IN-1:0]        k_in_valid;
    logic [N_IN-1:0]        k_in_ready = '0;
    logic [N_OUT-1:0]       out_valid = '0;
    logic [N_OUT-1:0]       out_ready = '0;
    logic [N_IN-1:0]        in_evt;
    logic [N_OUT-1:0]       out_evt;
    logic [N_OUT*CNT_W-1:0] out_cnt;
    logic                   done;
    logic                   idle;
    logic                   err;

    multi_dataflow_kernel_adapter_mc #(
        .N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
        .tot_out_i(tot_out), .in_ratio_i(in_ratio),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .k_in_valid_o(k_in_valid), .k_in_ready_i(k_in_ready),
        .out_valid_i(out_valid), .out_ready_i(out_ready),
        .in_evt_o(in_evt), .out_evt_o(out_evt), .out_cnt_o(out_cnt),
        .done_o(done), .idle_o(idle), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (job level) ----------------
    // phase: 0 = waiting for a job, 1 = job running, 2 = completion cycle
    int  m_phase = 0;
    int  m_tot[N_OUT];
    int  m_ratio[N_IN];
    int  m_in_acc[N_IN];   // inputs accepted since job start
    int  m_out[N_OUT];     // outputs counted since job start
    bit  m_in_evt[N_IN];
    bit  m_out_evt[N_OUT];
    bit  m_err = 0;
    bit  m_all_done;

    // scenario statistics gathered from the DUT
    bit  cmp_en = 0;
    int  cyc = 0;
    int  n_done = 0;
    int  n_evt0 = 0;
    int  n_evt1 = 0;
    int  start_cyc = 0;
    int  done_cyc = 0;
    int  last_hs = 0;
    int  idle_rise = 0;
    bit  idle_prev = 0;

    logic [N_IN-1:0]        e_in_ready, e_k_valid, e_in_evt;
    logic [N_OUT-1:0]       e_out_evt;
    logic [N_OUT*CNT_W-1:0] e_cnt;

    always @(negedge clk) begin
        cyc++;
        if (cmp_en) begin
            for (int i = 0; i < N_IN; i++) begin
                e_in_ready[i] = (m_phase == 1) && k_in_ready[i];
                e_k_valid[i]  = (m_phase == 1) && in_valid[i];
                e_in_evt[i]   = m_in_evt[i];
            end
            for (int j = 0; j < N_OUT; j++) begin
                e_out_evt[j] = m_out_evt[j];
                e_cnt[j*CNT_W +: CNT_W] = m_out[j][CNT_W-1:0];
            end
            check("in_ready_o", 32'(in_ready), 32'(e_in_ready));
            check("k_in_valid_o", 32'(k_in_valid), 32'(e_k_valid));
            check("in_evt_o", 32'(in_evt), 32'(e_in_evt));
            check("out_evt_o", 32'(out_evt), 32'(e_out_evt));
            check("out_cnt_o", 32'(out_cnt), 32'(e_cnt));
            check("done_o", 32'(done), 32'(m_phase == 2));
            check("idle_o", 32'(idle), 32'(m_phase == 0));
            check("err_o", 32'(err), 32'(m_err));
        end

        if (start && idle) start_cyc = cyc;
        if (done) begin n_done++; done_cyc = cyc; end
        n_evt0 += int'(in_evt[0]);
        n_evt1 += int'(in_evt[1]);
        if (|(out_valid & out_ready)) last_hs = cyc;
        if (idle && !idle_prev) idle_rise = cyc;
        idle_prev = idle;

        // advance the model with the inputs the DUT samples at the next edge
        if (rst || clear) begin
            m_phase = 0;
            m_err   = 0;
            for (int i = 0; i < N_IN; i++) begin
                m_ratio[i] = 0; m_in_acc[i] = 0; m_in_evt[i] = 0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                m_tot[j] = 0; m_out[j] = 0; m_out_evt[j] = 0;
            end
        end else begin
            m_all_done = 1;
            for (int j = 0; j < N_OUT; j++)
                if (m_out[j] != m_tot[j]) m_all_done = 0;
            for (int i = 0; i < N_IN; i++) begin
                m_in_evt[i] = 0;
                if (m_phase == 1 && in_valid[i] && k_in_ready[i]) begin
                    m_in_acc[i]++;
                    if (m_in_acc[i] % m_ratio[i] == 0) m_in_evt[i] = 1;
                end
            end
            for (int j = 0; j < N_OUT; j++) begin
                m_out_evt[j] = out_valid[j] && out_ready[j];
                if (m_out_evt[j]) begin
                    if (m_phase != 1 || m_out[j] >= m_tot[j]) m_err = 1;
                    else m_out[j]++;
                end
            end
            case (m_phase)
                0: if (start) begin
                    for (int j = 0; j < N_OUT; j++) begin
                        m_tot[j] = int'(tot_out[j*CNT_W +: CNT_W]);
                        m_out[j] = 0;
                    end
                    for (int i = 0; i < N_IN; i++) begin
                        m_ratio[i]  = int'(in_ratio[i*CNT_W +: CNT_W]);
                        if (m_ratio[i] == 0) m_ratio[i] = 1;
                        m_in_acc[i] = 0;
                    end
                    m_phase = 1;
                end
                1: if (m_all_done) m_phase = 2;
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_out(input logic [N_OUT-1:0] v);
        out_valid = v;
        out_ready = v;
    endtask

    task automatic clr_stats();
        n_done = 0;
        n_evt0 = 0;
        n_evt1 = 0;
    endtask

    task automatic start_job(input logic [N_OUT*CNT_W-1:0] tot, input logic [N_IN*CNT_W-1:0] ratio);
        tot_out  = tot;
        in_ratio = ratio;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int k = 0;
        while (n_done == 0 && k < max_cyc) begin
            step();
            k++;
        end
        check("done_within_bound", 32'(n_done != 0), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset state
        step();
        step();
        cmp_en = 1;
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(out_cnt), 32'd0);
        rst = 1'b0;
        step();

        // 1: tot={4,4}, ratio={1,2}
        clr_stats();
        start_job(8'h44, 8'h21);
        in_valid = 2'b11; k_in_ready = 2'b11;
        repeat (4) step();
        in_valid = 2'b00;
        set_out(2'b11);
        repeat (4) step();
        set_out(2'b00);
        wait_done(10);
        step();
        check("t1_evt0", 32'(n_evt0), 32'd4);
        check("t1_evt1", 32'(n_evt1), 32'd2);
        check("t1_done_cnt", 32'(n_done), 32'd1);
        check("t1_done_lat", 32'(done_cyc - last_hs), 32'd2);
        check("t1_idle_lat", 32'(idle_rise - done_cyc), 32'd1);
        check("t1_err", 32'(err), 32'd0);

        // 2: tot={3,6}, stream 0 finishes early
        clr_stats();
        start_job(8'h63, 8'h11);
        set_out(2'b11);
        repeat (3) step();
        set_out(2'b10);
        repeat (2) step();
        set_out(2'b00);
        repeat (3) step();
        check("t2_no_early_done", 32'(n_done), 32'd0);
        check("t2_cnt_hold", 32'(out_cnt), 32'h53);
        set_out(2'b10);
        step();
        set_out(2'b00);
        wait_done(10);
        step();
        check("t2_done_lat", 32'(done_cyc - last_hs), 32'd2);
        check("t2_cnt_final", 32'(out_cnt), 32'h63);
        check("t2_err", 32'(err), 32'd0);

        // 3: all-zero totals
        clr_stats();
        start_job(8'h00, 8'h11);
        wait_done(10);
        step();
        check("t3_done_lat", 32'(done_cyc - start_cyc), 32'd2);
        check("t3_no_evt", 32'(n_evt0 + n_evt1), 32'd0);

        // 4a: output while idle -> sticky error, cleared by clear_i
        set_out(2'b01);
        step();
        set_out(2'b00);
        check("t4_err_set", 32'(err), 32'd1);
        repeat (3) step();
        check("t4_err_sticky", 32'(err), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t4_clr_err", 32'(err), 32'd0);
        check("t4_clr_idle", 32'(idle), 32'd1);
        check("t4_clr_evt", 32'(out_evt), 32'd0);

        // 4b: extra beat on a saturated stream
        clr_stats();
        start_job(8'h21, 8'h11);
        set_out(2'b01);
        repeat (2) step();
        set_out(2'b00);
        step();
        check("t4_sat_err", 32'(err), 32'd1);
        check("t4_sat_cnt", 32'(out_cnt), 32'h01);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        check("t4_abort_idle", 32'(idle), 32'd1);
        check("t4_abort_cnt", 32'(out_cnt), 32'd0);
        check("t4_abort_done", 32'(n_done), 32'd0);

        // 5: start during RUN ignored, then reset mid-job
        clr_stats();
        start_job(8'h55, 8'h11);
        in_valid = 2'b11; k_in_ready = 2'b11;
        set_out(2'b11);
        repeat (2) step();
        set_out(2'b00);
        start_job(8'h22, 8'h11);
        step();
        check("t5_restart_ignored", 32'(n_done), 32'd0);
        check("t5_still_run", 32'(idle), 32'd0);
        check("t5_cnt_kept", 32'(out_cnt), 32'h22);
        set_out(2'b11);
        step();
        set_out(2'b00);
        step();
        check("t5_cnt_next", 32'(out_cnt), 32'h33);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_ready", 32'(in_ready), 32'd0);
        check("t5_rst_idle", 32'(idle), 32'd1);
        repeat (3) step();
        check("t5_rst_no_done", 32'(n_done), 32'd0);
        in_valid = 2'b00;

        // 6: ratio 0 treated as 1, tot=15 reached without wrap
        clr_stats();
        start_job(8'h0F, 8'h00);
        in_valid = 2'b11;
        repeat (5) step();
        in_valid = 2'b00;
        set_out(2'b01);
        repeat (15) step();
        set_out(2'b00);
        wait_done(10);
        step();
        check("t6_evt0", 32'(n_evt0), 32'd5);
        check("t6_evt1", 32'(n_evt1), 32'd5);
        check("t6_cnt15", 32'(out_cnt), 32'h0F);
        check("t6_done_lat", 32'(done_cyc - last_hs), 32'd2);
        check("t6_err", 32'(err), 32'd0);

        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
